// File: rtl/ysyx_23060236_mtime_reader.sv
// AXI-lite read initiator that returns a coherent 64-bit mtime snapshot from the CLINT.
// The sequence is high, low, high; if the two high reads disagree, a carry crossed the
// low word, so the low word is re-read and the high word is compared again.
module ysyx_23060236_mtime_reader #(
  parameter logic [31:0] BASE_ADDR = 32'h0200_0000,
  parameter int unsigned MAX_RETRY = 3
) (
  input  logic        clock,
  input  logic        reset,
  // Snapshot request/response side
  input  logic        req_valid,
  output logic        req_ready,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [63:0] resp_data,
  output logic [1:0]  resp_err,
  // CLINT read port
  output logic [31:0] araddr,
  output logic        arvalid,
  input  logic        arready,
  input  logic [31:0] rdata,
  input  logic [1:0]  rresp,
  input  logic        rvalid,
  output logic        rready
);

  localparam int unsigned CntW = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);
  localparam logic [CntW-1:0] MaxRetryC = CntW'(MAX_RETRY);
  localparam logic [31:0] HiAddr = BASE_ADDR + 32'd4;

  typedef enum logic [2:0] {
    StIdle,
    StArHi1,
    StRHi1,
    StArLo,
    StRLo,
    StArHi2,
    StRHi2,
    StDone
  } state_e;

  state_e          state_q, state_d;
  logic [31:0]     hi1_q, hi1_d;
  logic [31:0]     lo_q, lo_d;
  logic [CntW-1:0] retry_cnt_q, retry_cnt_d;
  logic            req_ready_q, req_ready_d;
  logic            arvalid_q, arvalid_d;
  logic            rready_q, rready_d;
  logic [31:0]     araddr_q, araddr_d;
  logic            resp_valid_q, resp_valid_d;
  logic [63:0]     resp_data_q, resp_data_d;
  logic [1:0]      resp_err_q, resp_err_d;

  logic ar_hs;
  logic r_hs;
  logic r_bad;

  assign ar_hs = arvalid_q & arready;
  assign r_hs  = rvalid & rready_q;
  assign r_bad = (rresp != 2'b00);

  // Next-state logic; every output is registered and decoded from the next state.
  always_comb begin
    state_d      = state_q;
    hi1_d        = hi1_q;
    lo_d         = lo_q;
    retry_cnt_d  = retry_cnt_q;
    resp_data_d  = resp_data_q;
    resp_err_d   = resp_err_q;
    araddr_d     = araddr_q;

    unique case (state_q)
      StIdle: begin
        if (req_valid && req_ready_q) begin
          state_d     = StArHi1;
          retry_cnt_d = '0;
          resp_err_d  = '0;
        end
      end
      StArHi1: if (ar_hs) state_d = StRHi1;
      StArLo:  if (ar_hs) state_d = StRLo;
      StArHi2: if (ar_hs) state_d = StRHi2;
      StRHi1: begin
        if (r_hs) begin
          if (r_bad) begin
            state_d       = StDone;
            resp_err_d[0] = 1'b1;
            resp_data_d   = '0;
          end else begin
            hi1_d   = rdata;
            state_d = StArLo;
          end
        end
      end
      StRLo: begin
        if (r_hs) begin
          if (r_bad) begin
            state_d       = StDone;
            resp_err_d[0] = 1'b1;
            resp_data_d   = '0;
          end else begin
            lo_d    = rdata;
            state_d = StArHi2;
          end
        end
      end
      StRHi2: begin
        if (r_hs) begin
          if (r_bad) begin
            state_d       = StDone;
            resp_err_d[0] = 1'b1;
            resp_data_d   = '0;
          end else if (rdata == hi1_q) begin
            state_d     = StDone;
            resp_data_d = {rdata, lo_q};
          end else if (retry_cnt_q < MaxRetryC) begin
            // High word moved: the new high value becomes the reference, re-read low only.
            hi1_d       = rdata;
            retry_cnt_d = retry_cnt_q + 1'b1;
            state_d     = StArLo;
          end else begin
            state_d       = StDone;
            resp_err_d[1] = 1'b1;
            resp_data_d   = '0;
          end
        end
      end
      StDone: if (resp_ready) state_d = StIdle;
      default: state_d = StIdle;
    endcase

    req_ready_d  = (state_d == StIdle);
    arvalid_d    = (state_d == StArHi1) || (state_d == StArLo) || (state_d == StArHi2);
    rready_d     = (state_d == StRHi1) || (state_d == StRLo) || (state_d == StRHi2);
    resp_valid_d = (state_d == StDone);
    if (state_d == StArLo) begin
      araddr_d = BASE_ADDR;
    end else if ((state_d == StArHi1) || (state_d == StArHi2)) begin
      araddr_d = HiAddr;
    end
  end

  // State and registered outputs with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= StIdle;
      hi1_q        <= '0;
      lo_q         <= '0;
      retry_cnt_q  <= '0;
      req_ready_q  <= 1'b1;
      arvalid_q    <= 1'b0;
      rready_q     <= 1'b0;
      araddr_q     <= '0;
      resp_valid_q <= 1'b0;
      resp_data_q  <= '0;
      resp_err_q   <= '0;
    end else begin
      state_q      <= state_d;
      hi1_q        <= hi1_d;
      lo_q         <= lo_d;
      retry_cnt_q  <= retry_cnt_d;
      req_ready_q  <= req_ready_d;
      arvalid_q    <= arvalid_d;
      rready_q     <= rready_d;
      araddr_q     <= araddr_d;
      resp_valid_q <= resp_valid_d;
      resp_data_q  <= resp_data_d;
      resp_err_q   <= resp_err_d;
    end
  end

  assign req_ready  = req_ready_q;
  assign arvalid    = arvalid_q;
  assign rready     = rready_q;
  assign araddr     = araddr_q;
  assign resp_valid = resp_valid_q;
  assign resp_data  = resp_data_q;
  assign resp_err   = resp_err_q;

endmodule

// File: tb/tb_ysyx_23060236_mtime_reader.sv
// Bench for the mtime snapshot reader: a scripted AXI-lite read responder plus a table of
// snapshot scenarios with hand-computed results, and a mid-operation reset sequence.
module tb_ysyx_23060236_mtime_reader;

  localparam logic [31:0] LoAddr = 32'h0200_0000;
  localparam logic [31:0] HiAddr = 32'h0200_0004;

  logic        clock;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        resp_valid;
  logic        resp_ready;
  logic [63:0] resp_data;
  logic [1:0]  resp_err;
  logic [31:0] araddr;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready;

  ysyx_23060236_mtime_reader #(
    .BASE_ADDR(32'h0200_0000),
    .MAX_RETRY(3)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .resp_valid(resp_valid),
    .resp_ready(resp_ready),
    .resp_data (resp_data),
    .resp_err  (resp_err),
    .araddr    (araddr),
    .arvalid   (arvalid),
    .arready   (arready),
    .rdata     (rdata),
    .rresp     (rresp),
    .rvalid    (rvalid),
    .rready    (rready)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_chk;
  int n_fail;

  task automatic chk(input bit ok, input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    n_chk++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Responder script: one {data, resp} per read beat, consumed in order.
  logic [31:0] rd_data_q[$];
  logic [1:0]  rd_resp_q[$];
  logic [31:0] ar_log[$];
  bit          stall_en;
  int          ar_wait;
  int          r_wait;
  bit          phase;
  bit          ar_pend;
  bit          r_pend;
  bit          ar_hold;
  logic [31:0] ar_seen_addr;
  logic [31:0] ar_hold_addr;

  // Responder, acting 1 time unit after each rising edge; also checks AR stability and rready.
  initial begin
    arready  = 1'b0;
    rvalid   = 1'b0;
    rdata    = '0;
    rresp    = '0;
    phase    = 1'b0;
    ar_pend  = 1'b0;
    r_pend   = 1'b0;
    ar_hold  = 1'b0;
    r_wait   = 0;
    forever begin
      @(posedge clock);
      #1;
      if (reset) begin
        arready = 1'b0;
        rvalid  = 1'b0;
        phase   = 1'b0;
        ar_pend = 1'b0;
        r_pend  = 1'b0;
        ar_hold = 1'b0;
      end else begin
        if (ar_pend) begin
          ar_log.push_back(ar_seen_addr);
          phase  = 1'b1;
          r_wait = stall_en ? int'($urandom_range(0, 5)) : 0;
        end
        if (r_pend) begin
          if (rd_data_q.size() > 0) begin
            void'(rd_data_q.pop_front());
            void'(rd_resp_q.pop_front());
          end
          phase   = 1'b0;
          ar_wait = stall_en ? int'($urandom_range(0, 5)) : 0;
        end
        if (ar_hold) begin
          chk(arvalid === 1'b1, "arvalid_held", {63'd0, arvalid}, 64'd1);
          chk(araddr === ar_hold_addr, "araddr_held", {32'd0, araddr}, {32'd0, ar_hold_addr});
        end
        chk(rready === phase, "rready_only_in_r", {63'd0, rready}, {63'd0, phase});
        arready = 1'b0;
        rvalid  = 1'b0;
        rdata   = '0;
        rresp   = '0;
        if (!phase && arvalid) begin
          if (ar_wait > 0) ar_wait--;
          else arready = 1'b1;
        end
        if (phase) begin
          if (r_wait > 0) begin
            r_wait--;
          end else begin
            rvalid = 1'b1;
            if (rd_data_q.size() > 0) begin
              rdata = rd_data_q[0];
              rresp = rd_resp_q[0];
            end else begin
              rdata = 32'hDEAD_BEEF;
            end
          end
        end else if (stall_en) begin
          // Stray beat outside a read phase; must be ignored.
          rvalid = 1'($urandom_range(0, 1));
          rdata  = 32'hBAD0_0000;
        end
        ar_pend      = arvalid && arready;
        ar_seen_addr = araddr;
        ar_hold      = arvalid && !arready;
        ar_hold_addr = araddr;
        r_pend       = rvalid && rready;
      end
    end
  end

  typedef struct {
    string       name;
    int          n;
    logic [31:0] d[9];
    logic [1:0]  r[9];
    bit          stall;
    int          rdly;
    logic [63:0] exp_data;
    logic [1:0]  exp_err;
    int          exp_ar;
    int          exp_lat;
  } vec_t;

  function automatic vec_t mk(input string name, input int n,
                              input logic [31:0] d0, d1, d2, d3, d4, d5, d6, d7, d8,
                              input int err_at, input logic [1:0] err_code, input bit stall,
                              input int rdly, input logic [63:0] exp_data,
                              input logic [1:0] exp_err, input int exp_ar, input int exp_lat);
    vec_t v;
    v.name = name;
    v.n = n;
    v.d[0] = d0; v.d[1] = d1; v.d[2] = d2; v.d[3] = d3; v.d[4] = d4;
    v.d[5] = d5; v.d[6] = d6; v.d[7] = d7; v.d[8] = d8;
    for (int i = 0; i < 9; i++) v.r[i] = (i == err_at) ? err_code : 2'b00;
    v.stall = stall;
    v.rdly = rdly;
    v.exp_data = exp_data;
    v.exp_err = exp_err;
    v.exp_ar = exp_ar;
    v.exp_lat = exp_lat;
    return v;
  endfunction

  task automatic run_vec(input vec_t v);
    int  lat;
    bit  got;
    logic [31:0] exp_addr;
    rd_data_q.delete();
    rd_resp_q.delete();
    ar_log.delete();
    for (int i = 0; i < v.n; i++) begin
      rd_data_q.push_back(v.d[i]);
      rd_resp_q.push_back(v.r[i]);
    end
    @(negedge clock);
    stall_en = v.stall;
    ar_wait  = v.stall ? int'($urandom_range(0, 5)) : 0;
    chk(req_ready === 1'b1, {v.name, ".req_ready_idle"}, {63'd0, req_ready}, 64'd1);
    req_valid = 1'b1;
    @(posedge clock);
    #1 req_valid = 1'b0;
    lat = 0;
    got = 1'b0;
    for (int k = 1; k <= 400 && !got; k++) begin
      @(posedge clock);
      #1;
      if (resp_valid) begin
        got = 1'b1;
        lat = k;
      end
    end
    chk(got, {v.name, ".resp_timeout"}, {63'd0, got}, 64'd1);
    if (v.exp_lat >= 0) chk(lat == v.exp_lat, {v.name, ".latency"}, 64'(lat), 64'(v.exp_lat));
    chk(resp_data === v.exp_data, {v.name, ".resp_data"}, resp_data, v.exp_data);
    chk(resp_err === v.exp_err, {v.name, ".resp_err"}, {62'd0, resp_err}, {62'd0, v.exp_err});
    chk(ar_log.size() == v.exp_ar, {v.name, ".ar_count"}, 64'(ar_log.size()), 64'(v.exp_ar));
    for (int i = 0; i < ar_log.size() && i < v.exp_ar; i++) begin
      exp_addr = (i == 0 || (i % 2) == 0) ? HiAddr : LoAddr;
      chk(ar_log[i] === exp_addr, {v.name, ".araddr_seq"}, {32'd0, ar_log[i]},
          {32'd0, exp_addr});
    end
    for (int i = 0; i < v.rdly; i++) begin
      @(negedge clock);
      chk(resp_valid === 1'b1, {v.name, ".resp_valid_held"}, {63'd0, resp_valid}, 64'd1);
      chk(resp_data === v.exp_data, {v.name, ".resp_data_held"}, resp_data, v.exp_data);
      chk(req_ready === 1'b0, {v.name, ".req_ready_done"}, {63'd0, req_ready}, 64'd0);
    end
    @(negedge clock);
    resp_ready = 1'b1;
    @(posedge clock);
    #1 resp_ready = 1'b0;
    chk(resp_valid === 1'b0, {v.name, ".resp_valid_drop"}, {63'd0, resp_valid}, 64'd0);
    chk(req_ready === 1'b1, {v.name, ".req_ready_back"}, {63'd0, req_ready}, 64'd1);
    stall_en = 1'b0;
  endtask

  vec_t vecs[8];
  bit   found;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    n_chk      = 0;
    n_fail     = 0;
    reset      = 1'b1;
    req_valid  = 1'b0;
    resp_ready = 1'b0;
    stall_en   = 1'b0;
    ar_wait    = 0;

    vecs[0] = mk("stable", 3, 32'h1, 32'h10, 32'h1, 0, 0, 0, 0, 0, 0, -1, 2'b00, 1'b0, 1,
                 64'h0000_0001_0000_0010, 2'b00, 3, 6);
    vecs[1] = mk("rollover", 5, 32'h0, 32'hFFFF_FFFF, 32'h1, 32'h2, 32'h1, 0, 0, 0, 0,
                 -1, 2'b00, 1'b0, 0, 64'h0000_0001_0000_0002, 2'b00, 5, 10);
    vecs[2] = mk("retry_exhaust", 9, 32'h0, 32'hA, 32'h1, 32'hB, 32'h2, 32'hC, 32'h3, 32'hD,
                 32'h4, -1, 2'b00, 1'b0, 0, 64'h0, 2'b10, 9, 18);
    vecs[3] = mk("last_retry_ok", 9, 32'h0, 32'hA, 32'h1, 32'hB, 32'h2, 32'hC, 32'h3, 32'hD,
                 32'h3, -1, 2'b00, 1'b0, 0, 64'h0000_0003_0000_000D, 2'b00, 9, 18);
    vecs[4] = mk("lo_slverr", 2, 32'h5, 32'h1234, 0, 0, 0, 0, 0, 0, 0, 1, 2'b10, 1'b0, 1,
                 64'h0, 2'b01, 2, 4);
    vecs[5] = mk("hi1_decerr", 1, 32'h5, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b11, 1'b0, 0,
                 64'h0, 2'b01, 1, 2);
    vecs[6] = mk("stall_stable", 3, 32'hABCD, 32'h1234_5678, 32'hABCD, 0, 0, 0, 0, 0, 0,
                 -1, 2'b00, 1'b1, 3, 64'h0000_ABCD_1234_5678, 2'b00, 3, -1);
    vecs[7] = mk("stall_retry", 5, 32'h7, 32'h9, 32'h8, 32'h55, 32'h8, 0, 0, 0, 0,
                 -1, 2'b00, 1'b1, 3, 64'h0000_0008_0000_0055, 2'b00, 5, -1);

    repeat (3) @(negedge clock);
    chk(req_ready === 1'b1, "rst.req_ready", {63'd0, req_ready}, 64'd1);
    chk(arvalid === 1'b0, "rst.arvalid", {63'd0, arvalid}, 64'd0);
    chk(rready === 1'b0, "rst.rready", {63'd0, rready}, 64'd0);
    chk(araddr === 32'd0, "rst.araddr", {32'd0, araddr}, 64'd0);
    chk(resp_valid === 1'b0, "rst.resp_valid", {63'd0, resp_valid}, 64'd0);
    chk(resp_data === 64'd0, "rst.resp_data", resp_data, 64'd0);
    chk(resp_err === 2'b00, "rst.resp_err", {62'd0, resp_err}, 64'd0);
    reset = 1'b0;

    for (int i = 0; i < 8; i++) run_vec(vecs[i]);

    // Reset while waiting for the low-word read data.
    rd_data_q.delete();
    rd_resp_q.delete();
    ar_log.delete();
    rd_data_q.push_back(32'h1); rd_resp_q.push_back(2'b00);
    rd_data_q.push_back(32'h2); rd_resp_q.push_back(2'b00);
    rd_data_q.push_back(32'h1); rd_resp_q.push_back(2'b00);
    @(negedge clock);
    req_valid = 1'b1;
    @(posedge clock);
    #1 req_valid = 1'b0;
    found = 1'b0;
    for (int k = 0; k < 50 && !found; k++) begin
      @(negedge clock);
      if (rready === 1'b1 && ar_log.size() == 2) found = 1'b1;
    end
    chk(found, "mid_rst.reach_r_lo", {63'd0, found}, 64'd1);
    reset = 1'b1;
    @(posedge clock);
    #1;
    chk(arvalid === 1'b0, "mid_rst.arvalid", {63'd0, arvalid}, 64'd0);
    chk(rready === 1'b0, "mid_rst.rready", {63'd0, rready}, 64'd0);
    chk(req_ready === 1'b1, "mid_rst.req_ready", {63'd0, req_ready}, 64'd1);
    chk(resp_valid === 1'b0, "mid_rst.resp_valid", {63'd0, resp_valid}, 64'd0);
    chk(resp_err === 2'b00, "mid_rst.resp_err", {62'd0, resp_err}, 64'd0);
    @(negedge clock);
    reset = 1'b0;
    run_vec(vecs[0]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/ysyx_23060236_mtime_reader.md
Name: ysyx_23060236_mtime_reader

Overview:
- AXI-lite read-channel initiator that fetches a coherent 64-bit mtime snapshot from the CLINT.
- The CLINT exposes mtime as two 32-bit words, and araddr[2] selects the high word.
- The block uses a hi-lo-hi read sequence and retries when the high word changed between the two high reads.
- It sits between the core's CSR/timer logic (request/response side) and the CLINT read port (AR/R side).

Parameters:
- BASE_ADDR, 32'h0200_0000, address of the mtime low word; the high word is at BASE_ADDR+4.
- MAX_RETRY, 3, maximum number of re-reads after a high-word mismatch before reporting an error.

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high reset
- req_valid  in  1  snapshot request
- req_ready  out  1  high only in IDLE
- resp_valid  out  1  snapshot result valid
- resp_ready  in  1  consumer accepts the result
- resp_data  out  64  mtime snapshot
- resp_err  out  2  [0] bus error (rresp!=0); [1] retry limit exhausted
- araddr  out  32  read address
- arvalid  out  1  read address valid
- arready  in  1  responder accepts the address
- rdata  in  32  read data
- rresp  in  2  read response
- rvalid  in  1  read data valid
- rready  out  1  initiator accepts read data

Behaviour:
- Single clock; synchronous, active-high reset.
- Reset values:
  - state=IDLE, req_ready=1, arvalid=0, rready=0, araddr=0.
  - resp_valid=0, resp_data=0, resp_err=0, retry_cnt=0.
- States: IDLE, AR_HI1, R_HI1, AR_LO, R_LO, AR_HI2, R_HI2, DONE.
- IDLE:
  - On req_valid & req_ready: go to AR_HI1, clear retry_cnt, clear resp_err.
- AR_x states:
  - arvalid=1, araddr = BASE_ADDR+4 for the HI states and BASE_ADDR for LO.
  - arvalid and araddr stay stable until arready.
  - On arvalid & arready: go to the matching R_x state.
  - arvalid never drops without a handshake, except on reset.
- R_x states:
  - rready=1; rready is 0 in every other state.
  - On rvalid & rready: capture rdata into hi1, lo or hi2.
- Bus error:
  - If rresp!=0 on any R handshake: go to DONE with resp_err[0]=1 and resp_data=0.
- Sequencing:
  - R_HI1 → AR_LO.
  - R_LO → AR_HI2.
- R_HI2 resolution:
  - If rdata==hi1: go to DONE, resp_data={rdata, lo}.
  - Else if retry_cnt<MAX_RETRY: hi1<=rdata, retry_cnt++, go to AR_LO (re-read low only).
  - Else: go to DONE with resp_err[1]=1 and resp_data=0.
- DONE:
  - resp_valid=1; resp_data and resp_err are held stable.
  - On resp_ready: go to IDLE and drop resp_valid.
  - req_ready is 0 in DONE, so there is no same-cycle re-accept; a new request is accepted earliest one cycle after the response handshake.
- Latency:
  - With a zero-wait responder (arready=1 while idle, rvalid the cycle after the address), resp_valid asserts 6 clock edges after the accepting edge.
  - Each retry adds 4 edges.
- Wait states: any number of cycles with arready=0 or rvalid=0 simply hold the current state.
- Stray rvalid: rvalid asserted outside the R states is ignored, because rready=0.
- Reset mid-operation: the next edge returns the block to IDLE with all outputs at their reset values; any outstanding transaction is abandoned (the responder shares the same reset).
- Retry counter: retry_cnt is sized clog2(MAX_RETRY+1) and never wraps.

Test Plan:
- Zero-wait responder, mtime hi=0x0000_0001, lo=0x0000_0010, stable:
  - Expect ARs at 0x0200_0004, 0x0200_0000, 0x0200_0004.
  - Expect resp_data=0x0000_0001_0000_0010, resp_err=0, resp_valid 6 edges after accept.
- Rollover: hi1=0x0, lo=0xFFFF_FFFF, hi2=0x1, then lo=0x0000_0002, hi=0x1:
  - Expect exactly 5 AR handshakes.
  - Expect resp_data=0x0000_0001_0000_0002, resp_err=0.
- High word changes on every read:
  - Expect 1+MAX_RETRY re-read pairs (3+2·3=9 ARs), then resp_err=2'b10, resp_data=0.
- rresp=2'b10 on the low read:
  - Expect no further AR, resp_err=2'b01, resp_data=0.
- Random arready/rvalid stalls of 0–5 cycles:
  - Expect araddr/arvalid held until handshake, rready asserted only in R states.
  - Expect correct data; resp_valid held until resp_ready is asserted, with resp_ready delayed 3 cycles.
- Reset asserted in R_LO:
  - Next edge: arvalid=0, rready=0, req_ready=1, resp_valid=0.
  - A following request completes normally.
